icm_lookup_arbiter: RTL

- Shares one ICM mapping lookup channel (lookup request plus in-order mapping response) among NUM_REQ requesters, e.g. the software-access MR thread and the hardware MPT/MTT miss path.
- Selects requesters round-robin, registers the lookup request and records which requester was granted in an outstanding-tag FIFO.
- Returns each mapping response to the requester at the FIFO head.
- One instance sits in front of each ICM table (MPT, MTT) inside MRMgt.

---
 rtl/icm_lookup_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/icm_lookup_arbiter.sv
// icm_lookup_arbiter: shares one ICM mapping lookup channel among NUM_REQ requesters.
// Round-robin grant into a single registered lookup stage; an outstanding-tag FIFO
// remembers who was granted so in-order mapping responses can be routed back.
// Optional performance counters are compiled in with ICM_LOOKUP_ARB_PERF_EN.
module icm_lookup_arbiter #(
    parameter int NUM_REQ           = 2,
    parameter int IDX_WIDTH         = 16,
    parameter int ICM_ADDR_WIDTH    = 64,
    parameter int PHY_ADDR_WIDTH    = 64,
    parameter int OUTSTANDING_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*IDX_WIDTH-1:0]   req_head,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           icm_mapping_lookup_valid,
    output logic [IDX_WIDTH-1:0]           icm_mapping_lookup_head,
    input  logic                           icm_mapping_lookup_ready,
    input  logic                           icm_mapping_rsp_valid,
    input  logic [ICM_ADDR_WIDTH-1:0]      icm_mapping_rsp_icm_addr,
    input  logic [PHY_ADDR_WIDTH-1:0]      icm_mapping_rsp_phy_addr,
    output logic                           icm_mapping_rsp_ready,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [ICM_ADDR_WIDTH-1:0]      rsp_icm_addr,
    output logic [PHY_ADDR_WIDTH-1:0]      rsp_phy_addr,
    input  logic [NUM_REQ-1:0]             rsp_ready,
    output logic                           orphan_rsp_err
`ifdef ICM_LOOKUP_ARB_PERF_EN
    ,
    output logic [NUM_REQ*32-1:0]          perf_grant_cnt,
    output logic [31:0]                    perf_full_stall_cnt
`endif
);

    localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = (OUTSTANDING_DEPTH > 1) ? $clog2(OUTSTANDING_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(OUTSTANDING_DEPTH);
    localparam logic [TAG_W-1:0] LAST_REQ  = TAG_W'(NUM_REQ - 1);
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(OUTSTANDING_DEPTH - 1);

    typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;

    out_state_t           out_state;
    logic [IDX_WIDTH-1:0] lookup_head_q;
    logic [TAG_W-1:0]     tag_mem [OUTSTANDING_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [TAG_W-1:0]     rr_ptr;
    logic                 orphan_q;

    logic                 any_valid;
    logic [TAG_W-1:0]     win_idx;
    logic [IDX_WIDTH-1:0] win_head;
    logic                 load_ok;
    logic                 grant;
    logic                 fifo_empty;
    logic [TAG_W-1:0]     head_tag;
    logic                 pop;

    // Round-robin pick: lowest valid index above the pointer, else lowest valid overall
    always_comb begin
        any_valid = 1'b0;
        win_idx   = '0;
        win_head  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                any_valid = 1'b1;
                win_idx   = TAG_W'(i);
                win_head  = req_head[i*IDX_WIDTH +: IDX_WIDTH];
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (i > int'(rr_ptr))) begin
                win_idx  = TAG_W'(i);
                win_head = req_head[i*IDX_WIDTH +: IDX_WIDTH];
            end
        end
    end

    // The register may load when it is empty or draining, and a tag slot is free
    assign load_ok = ((out_state == OUT_EMPTY) || icm_mapping_lookup_ready) && (count < DEPTH_C);
    assign grant   = rst && any_valid && load_ok;

    // One-hot accept for the winner only
    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    assign fifo_empty = (count == '0);
    assign head_tag   = tag_mem[rd_ptr];
    assign pop        = !fifo_empty && icm_mapping_rsp_valid && rsp_ready[head_tag];

    // Route the response to the requester at the FIFO head; drop it when nobody is waiting
    always_comb begin
        rsp_valid             = '0;
        icm_mapping_rsp_ready = 1'b1;
        if (!fifo_empty) begin
            rsp_valid[head_tag]   = icm_mapping_rsp_valid;
            icm_mapping_rsp_ready = rsp_ready[head_tag];
        end
    end

    assign rsp_icm_addr             = icm_mapping_rsp_icm_addr;
    assign rsp_phy_addr             = icm_mapping_rsp_phy_addr;
    assign icm_mapping_lookup_valid = (out_state == OUT_FULL);
    assign icm_mapping_lookup_head  = lookup_head_q;
    assign orphan_rsp_err           = orphan_q;

    // Output stage: holds the lookup until accepted, reloads directly on a grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_state     <= OUT_EMPTY;
            lookup_head_q <= '0;
        end else begin
            case (out_state)
                OUT_EMPTY: begin
                    if (grant) begin
                        out_state     <= OUT_FULL;
                        lookup_head_q <= win_head;
                    end
                end
                OUT_FULL: begin
                    if (grant) begin
                        lookup_head_q <= win_head;
                    end else if (icm_mapping_lookup_ready) begin
                        out_state <= OUT_EMPTY;
                    end
                end
                default: out_state <= OUT_EMPTY;
            endcase
        end
    end

    // Tag storage needs no reset: the pointers and count define which slots are live
    always_ff @(posedge clk) begin
        if (grant) begin
            tag_mem[wr_ptr] <= win_idx;
        end
    end

    // Tag FIFO pointers, occupancy, round-robin pointer and sticky orphan flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rr_ptr   <= LAST_REQ;
            orphan_q <= 1'b0;
        end else begin
            if (grant) begin
                wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
                rr_ptr <= win_idx;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + 1'b1;
            end
            if (grant && !pop) begin
                count <= count + 1'b1;
            end else if (!grant && pop) begin
                count <= count - 1'b1;
            end
            if (fifo_empty && icm_mapping_rsp_valid) begin
                orphan_q <= 1'b1;
            end
        end
    end

`ifdef ICM_LOOKUP_ARB_PERF_EN
    // Saturating per-requester grant counters and full-stall cycle counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_grant_cnt      <= '0;
            perf_full_stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant && (win_idx == TAG_W'(i)) && (perf_grant_cnt[i*32 +: 32] != 32'hFFFF_FFFF)) begin
                    perf_grant_cnt[i*32 +: 32] <= perf_grant_cnt[i*32 +: 32] + 32'd1;
                end
            end
            if ((|req_valid) && (count == DEPTH_C) && (perf_full_stall_cnt != 32'hFFFF_FFFF)) begin
                perf_full_stall_cnt <= perf_full_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
